// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch measurement monitor.
package glitch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        WIDTH  = 3'd2,
        REPORT = 3'd3,
        REARM  = 3'd4
    } mon_state_t;

    localparam int PLL_FREQ_HZ            = 204_000_000;
    localparam int CNT_W_DEFAULT          = 32;
    localparam int TIMEOUT_CYCLES_DEFAULT = 204_000_000;

    function automatic logic is_busy_state(input mon_state_t s);
        return (s == DELAY) || (s == WIDTH);
    endfunction

endpackage

// File: rtl/glitch_monitor_sync_edge.sv
// N-stage synchroniser with registered previous-value compare for rise/fall pulses.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain and edge-detect history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_r[SYNC_STAGES-1];
    assign rise     = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign fall     = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/glitch_monitor.sv
// Trigger-to-glitch delay and glitch width monitor with valid/ready result.
// Optional statistics outputs are enabled by defining GLITCH_MON_STATS_EN.
module glitch_monitor
    import glitch_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             glitch_in,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [CNT_W-1:0] delay_count,
    output logic [CNT_W-1:0] width_count,
    output logic             timeout,
    output logic             busy_indicator,
`ifdef GLITCH_MON_STATS_EN
    output logic             done_indicator,
    output logic [15:0]      event_count,
    output logic [CNT_W-1:0] max_width
`else
    output logic             done_indicator
`endif
);

    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE_C;
    endfunction

    logic trig_sync_s, trig_rise_s, trig_fall_s;
    logic glitch_sync_s, glitch_rise_s, glitch_fall_s;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (trigger),
        .sync_out (trig_sync_s),
        .rise     (trig_rise_s),
        .fall     (trig_fall_s)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_glitch_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (glitch_in),
        .sync_out (glitch_sync_s),
        .rise     (glitch_rise_s),
        .fall     (glitch_fall_s)
    );

    mon_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] dcnt_r, dcnt_nxt_s, dcnt_inc_s;
    logic [CNT_W-1:0] wcnt_r, wcnt_nxt_s, wcnt_inc_s;
    logic [CNT_W-1:0] delay_r, delay_nxt_s;
    logic [CNT_W-1:0] width_r, width_nxt_s;
    logic             timeout_r, timeout_nxt_s;
    logic             valid_r, busy_r, done_r;

    assign dcnt_inc_s = sat_inc(dcnt_r);
    assign wcnt_inc_s = sat_inc(wcnt_r);

    // Next-state and result-latch decisions
    always_comb begin
        state_nxt_s   = state_r;
        dcnt_nxt_s    = dcnt_r;
        wcnt_nxt_s    = wcnt_r;
        delay_nxt_s   = delay_r;
        width_nxt_s   = width_r;
        timeout_nxt_s = timeout_r;
        case (state_r)
            IDLE: begin
                dcnt_nxt_s = '0;
                wcnt_nxt_s = '0;
                if (trig_rise_s && glitch_rise_s) begin
                    delay_nxt_s   = '0;
                    timeout_nxt_s = 1'b0;
                    wcnt_nxt_s    = ONE_C;
                    state_nxt_s   = WIDTH;
                end else if (trig_rise_s) begin
                    state_nxt_s = DELAY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DELAY: begin
                dcnt_nxt_s = dcnt_inc_s;
                if (glitch_rise_s) begin
                    delay_nxt_s   = dcnt_inc_s;
                    timeout_nxt_s = 1'b0;
                    wcnt_nxt_s    = ONE_C;
                    state_nxt_s   = WIDTH;
                end else if (dcnt_inc_s >= TMO_C) begin
                    delay_nxt_s   = TMO_C;
                    width_nxt_s   = '0;
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = REPORT;
                end else begin
                    state_nxt_s = DELAY;
                end
            end
            WIDTH: begin
                if (glitch_fall_s || !glitch_sync_s) begin
                    width_nxt_s = wcnt_r;
                    state_nxt_s = REPORT;
                end else if (wcnt_inc_s >= TMO_C) begin
                    width_nxt_s   = TMO_C;
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = REPORT;
                end else begin
                    wcnt_nxt_s  = wcnt_inc_s;
                    state_nxt_s = WIDTH;
                end
            end
            REPORT: begin
                if (result_ready) begin
                    state_nxt_s = REARM;
                end else begin
                    state_nxt_s = REPORT;
                end
            end
            REARM: begin
                // Holding here until trigger is low blocks re-trigger on a held-high line
                if (!trig_sync_s || trig_fall_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REARM;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            dcnt_r    <= '0;
            wcnt_r    <= '0;
            delay_r   <= '0;
            width_r   <= '0;
            timeout_r <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            dcnt_r    <= dcnt_nxt_s;
            wcnt_r    <= wcnt_nxt_s;
            delay_r   <= delay_nxt_s;
            width_r   <= width_nxt_s;
            timeout_r <= timeout_nxt_s;
            valid_r   <= (state_nxt_s == REPORT);
            busy_r    <= is_busy_state(state_nxt_s);
            done_r    <= (state_nxt_s == REPORT);
        end
    end

    assign result_valid   = valid_r;
    assign delay_count    = delay_r;
    assign width_count    = width_r;
    assign timeout        = timeout_r;
    assign busy_indicator = busy_r;
    assign done_indicator = done_r;

`ifdef GLITCH_MON_STATS_EN
    logic [15:0]      event_cnt_r;
    logic [CNT_W-1:0] max_width_r;
    logic             accept_s;

    assign accept_s = (state_r == REPORT) && result_ready && !timeout_r;

    // Statistics over accepted, non-timeout results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_cnt_r <= 16'd0;
            max_width_r <= '0;
        end else if (accept_s) begin
            event_cnt_r <= (&event_cnt_r) ? event_cnt_r : event_cnt_r + 16'd1;
            max_width_r <= (width_r > max_width_r) ? width_r : max_width_r;
        end else begin
            event_cnt_r <= event_cnt_r;
            max_width_r <= max_width_r;
        end
    end

    assign event_count = event_cnt_r;
    assign max_width   = max_width_r;
`endif

endmodule

// File: tb/tb_glitch_monitor.sv
// Directed, table-driven bench for glitch_monitor with TIMEOUT_CYCLES = 100.
module tb_glitch_monitor;

    localparam int CNT_W = 32;
    localparam int TMO   = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             trigger = 1'b0;
    logic             glitch_in = 1'b0;
    logic             result_ready = 1'b1;
    logic             result_valid;
    logic [CNT_W-1:0] delay_count;
    logic [CNT_W-1:0] width_count;
    logic             timeout;
    logic             busy_indicator;
    logic             done_indicator;
`ifdef GLITCH_MON_STATS_EN
    logic [15:0]      event_count;
    logic [CNT_W-1:0] max_width;
`endif

    int checks = 0;
    int errors = 0;

    glitch_monitor #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trigger        (trigger),
        .glitch_in      (glitch_in),
        .result_ready   (result_ready),
        .result_valid   (result_valid),
        .delay_count    (delay_count),
        .width_count    (width_count),
        .timeout        (timeout),
        .busy_indicator (busy_indicator),
`ifdef GLITCH_MON_STATS_EN
        .done_indicator (done_indicator),
        .event_count    (event_count),
        .max_width      (max_width)
`else
        .done_indicator (done_indicator)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          dly;
        int          wid;   // 0: no glitch, -1: glitch stuck high
        logic [31:0] exp_delay;
        logic [31:0] exp_width;
        logic        exp_tmo;
    } vec_t;

    vec_t vecs[7];

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_meas(input int dly, input int wid);
        @(posedge clk);
        #1;
        trigger = 1'b1;
        if (wid != 0) begin
            repeat (dly) begin
                @(posedge clk);
                #1;
            end
            glitch_in = 1'b1;
            if (wid > 0) begin
                repeat (wid) begin
                    @(posedge clk);
                    #1;
                end
                glitch_in = 1'b0;
            end
        end
    endtask

    task automatic wait_result(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (result_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_inputs();
        trigger   = 1'b0;
        glitch_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic measure_and_check(input string tag, input int dly, input int wid,
                                     input logic [31:0] ed, input logic [31:0] ew,
                                     input logic et);
        logic seen;
        run_meas(dly, wid);
        wait_result(seen);
        check_b({tag, "_valid_seen"}, seen, 1'b1);
        check_w({tag, "_delay"}, delay_count, ed);
        check_w({tag, "_width"}, width_count, ew);
        check_b({tag, "_timeout"}, timeout, et);
        check_b({tag, "_done"}, done_indicator, 1'b1);
        @(negedge clk);
        check_b({tag, "_valid_one_cycle"}, result_valid, 1'b0);
        release_inputs();
    endtask

    initial begin
        logic seen;
        logic any_valid;
        logic any_busy;
        logic stable;

        vecs[0] = '{dly: 10, wid: 5,  exp_delay: 32'd10,  exp_width: 32'd5,   exp_tmo: 1'b0};
        vecs[1] = '{dly: 0,  wid: 3,  exp_delay: 32'd0,   exp_width: 32'd3,   exp_tmo: 1'b0};
        vecs[2] = '{dly: 1,  wid: 1,  exp_delay: 32'd1,   exp_width: 32'd1,   exp_tmo: 1'b0};
        vecs[3] = '{dly: 99, wid: 2,  exp_delay: 32'd99,  exp_width: 32'd2,   exp_tmo: 1'b0};
        vecs[4] = '{dly: 0,  wid: 0,  exp_delay: 32'd100, exp_width: 32'd0,   exp_tmo: 1'b1};
        vecs[5] = '{dly: 5,  wid: -1, exp_delay: 32'd5,   exp_width: 32'd100, exp_tmo: 1'b1};
        vecs[6] = '{dly: 7,  wid: 99, exp_delay: 32'd7,   exp_width: 32'd99,  exp_tmo: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check_b("rst_valid", result_valid, 1'b0);
        check_w("rst_delay", delay_count, 32'd0);
        check_w("rst_width", width_count, 32'd0);
        check_b("rst_timeout", timeout, 1'b0);
        check_b("rst_busy", busy_indicator, 1'b0);
        check_b("rst_done", done_indicator, 1'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        for (int v = 0; v < 7; v++) begin
            measure_and_check($sformatf("vec%0d", v), vecs[v].dly, vecs[v].wid,
                              vecs[v].exp_delay, vecs[v].exp_width, vecs[v].exp_tmo);
        end

        // Busy during the delay phase
        run_meas(0, 0);
        repeat (4) @(negedge clk);
        check_b("busy_in_delay", busy_indicator, 1'b1);
        wait_result(seen);
        check_b("busy_tmo_seen", seen, 1'b1);
        release_inputs();

        // Back-pressure: fields stable for 20 cycles, new trigger edge ignored
        result_ready = 1'b0;
        run_meas(4, 2);
        wait_result(seen);
        check_b("bp_valid_seen", seen, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) trigger = 1'b0;
            if (i == 10) trigger = 1'b1;
            @(negedge clk);
            stable = result_valid && (delay_count == 32'd4) && (width_count == 32'd2)
                     && !timeout && done_indicator;
            check_b($sformatf("bp_stable_%0d", i), stable, 1'b1);
        end
        result_ready = 1'b1;
        @(negedge clk);
        check_b("bp_valid_drop", result_valid, 1'b0);

        // Trigger still held high: no new measurement until it falls
        any_valid = 1'b0;
        any_busy  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            any_valid = any_valid | result_valid;
            any_busy  = any_busy | busy_indicator;
        end
        check_b("held_no_valid", any_valid, 1'b0);
        check_b("held_no_busy", any_busy, 1'b0);
        check_w("held_delay_kept", delay_count, 32'd4);
        release_inputs();
        measure_and_check("fresh", 3, 4, 32'd3, 32'd4, 1'b0);

        // Reset during the width phase
        run_meas(2, -1);
        repeat (5) @(negedge clk);
        check_b("w_busy", busy_indicator, 1'b1);
        check_w("w_delay_latched", delay_count, 32'd2);
        rst = 1'b1;
        #1;
        check_b("mid_rst_busy", busy_indicator, 1'b0);
        check_w("mid_rst_delay", delay_count, 32'd0);
        check_w("mid_rst_width", width_count, 32'd0);
        check_b("mid_rst_valid", result_valid, 1'b0);
        check_b("mid_rst_done", done_indicator, 1'b0);
        trigger   = 1'b0;
        glitch_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            any_valid = any_valid | result_valid | busy_indicator;
        end
        check_b("post_rst_quiet", any_valid, 1'b0);

`ifdef GLITCH_MON_STATS_EN
        check_w("stats_rst_events", {16'd0, event_count}, 32'd0);
        check_w("stats_rst_max", max_width, 32'd0);
        measure_and_check("st4", 2, 4, 32'd2, 32'd4, 1'b0);
        measure_and_check("st9", 2, 9, 32'd2, 32'd9, 1'b0);
        measure_and_check("st6", 2, 6, 32'd2, 32'd6, 1'b0);
        check_w("stats_events", {16'd0, event_count}, 32'd3);
        check_w("stats_max", max_width, 32'd9);
        measure_and_check("st_tmo", 0, 0, 32'd100, 32'd0, 1'b1);
        check_w("stats_events_tmo", {16'd0, event_count}, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
